// File: rtl/sort_host_if.sv
// Packetised valid/ready word stream. sort_host takes the slave side upstream
// and drives the master side downstream.
interface sort_host_if #(parameter int DW = 16);
  logic          valid;
  logic [DW-1:0] data;
  logic          last;
  logic          ready;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/sort_host.sv
// Host for a toggle-command insertion sorter: clears it, loads one packet,
// sorts it, then drains it downstream as a packet with out_last on the final word.
module sort_host #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int SETUP = 10,
  parameter int HOLD  = 2
) (
  input  logic          clk,
  input  logic          rst,
  sort_host_if.slave    up,
  sort_host_if.master   dn,
  output logic          push,
  output logic          pop,
  output logic          clear,
  output logic          sort,
  output logic [DW-1:0] din,
  input  logic [DW-1:0] dout,
  input  logic          full,
  input  logic          empty,
  input  logic          idle,
  output logic          err,
  output logic [3:0]    cst
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int WMAX = (SETUP > HOLD) ? SETUP : HOLD;
  localparam int WW   = $clog2(WMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CLR  = 4'd1,
    S_ACC  = 4'd2,
    S_SET  = 4'd3,
    S_PSH  = 4'd4,
    S_SRT  = 4'd5,
    S_CHK  = 4'd6,
    S_OUT  = 4'd7,
    S_POP  = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    PH_TOG  = 2'd0,
    PH_HOLD = 2'd1,
    PH_SYNC = 2'd2
  } phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [DW-1:0] din_q, din_d;
  logic          push_q, push_d;
  logic          pop_q, pop_d;
  logic          clear_q, clear_d;
  logic          sort_q, sort_d;
  logic          err_q, err_d;
  logic          issuing;
  logic          cmd_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= PH_TOG;
      wait_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      din_q   <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      clear_q <= 1'b0;
      sort_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      din_q   <= din_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      clear_q <= clear_d;
      sort_q  <= sort_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    wait_d   = wait_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    din_d    = din_q;
    push_d   = push_q;
    pop_d    = pop_q;
    clear_d  = clear_q;
    sort_d   = sort_q;
    err_d    = err_q;
    cmd_done = 1'b0;
    issuing  = (state_q == S_CLR) || (state_q == S_PSH) ||
               (state_q == S_SRT) || (state_q == S_POP);

    // Shared command handshake: one toggle, HOLD cycles of grace, then wait for idle.
    if (issuing) begin
      unique case (phase_q)
        PH_TOG: begin
          phase_d = PH_HOLD;
          wait_d  = WW'(HOLD);
          unique case (state_q)
            S_CLR:   clear_d = ~clear_q;
            S_PSH:   push_d  = ~push_q;
            S_SRT:   sort_d  = ~sort_q;
            default: pop_d   = ~pop_q;
          endcase
        end
        PH_HOLD: begin
          if (wait_q <= WW'(1)) phase_d = PH_SYNC;
          else                  wait_d  = wait_q - WW'(1);
        end
        default: begin
          if (idle) begin
            cmd_done = 1'b1;
            phase_d  = PH_TOG;
          end
        end
      endcase
    end

    unique case (state_q)
      S_IDLE: if (up.valid) state_d = S_CLR;
      S_CLR: begin
        if (cmd_done) begin
          cnt_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (full) begin
          state_d = S_SRT;
        end else if (up.valid) begin
          din_d   = up.data;
          last_d  = up.last;
          cnt_d   = cnt_q + CW'(1);
          wait_d  = WW'(SETUP);
          state_d = S_SET;
        end
      end
      S_SET: begin
        if (wait_q <= WW'(1)) state_d = S_PSH;
        else                  wait_d  = wait_q - WW'(1);
      end
      S_PSH: if (cmd_done) state_d = last_q ? S_SRT : S_ACC;
      S_SRT: if (cmd_done) state_d = S_CHK;
      S_CHK: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else if (empty) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (dn.ready) begin
          cnt_d   = cnt_q - CW'(1);
          state_d = S_POP;
        end
      end
      S_POP: begin
        if (cmd_done) begin
          if (cnt_q == '0 && !empty) err_d = 1'b1;
          state_d = S_CHK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign up.ready = (state_q == S_ACC) && !full && up.valid;
  assign dn.valid = (state_q == S_OUT);
  assign dn.data  = (state_q == S_OUT) ? dout : '0;
  assign dn.last  = (state_q == S_OUT) && (cnt_q == CW'(1));

  assign push  = push_q;
  assign pop   = pop_q;
  assign clear = clear_q;
  assign sort  = sort_q;
  assign din   = din_q;
  assign err   = err_q;
  assign cst   = state_q;

endmodule

// File: tb/tb_sort_host.sv
// Directed bench for sort_host against a behavioural toggle-command sorter model.
module tb_sort_host;
  localparam int DW = 16;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_PSH  = 4'd4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push, pop, clear, sort;
  logic [DW-1:0] din;
  logic [DW-1:0] dout = '0;
  logic          full = 1'b0, empty = 1'b1, idle = 1'b1;
  logic          err;
  logic [3:0]    cst;

  sort_host_if #(.DW(DW)) up_if ();
  sort_host_if #(.DW(DW)) dn_if ();

  sort_host #(.DW(DW), .DEPTH(16), .SETUP(10), .HOLD(2)) dut (
    .clk(clk), .rst(rst), .up(up_if), .dn(dn_if),
    .push(push), .pop(pop), .clear(clear), .sort(sort),
    .din(din), .dout(dout), .full(full), .empty(empty), .idle(idle),
    .err(err), .cst(cst)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] mem [0:31];
  int  n = 0, busy = 0, pops_since_clear = 0;
  bit  fake_empty = 1'b0;
  logic pc = 1'b0, pp = 1'b0, ps = 1'b0, pq = 1'b0;

  logic [DW-1:0] pkt  [0:31];
  logic [DW-1:0] expv [0:31];
  bit            expl [0:31];
  logic [DW-1:0] out_q [$];
  bit            outl_q [$];
  int            pop_at [$];
  int            acc_clr [$];

  int clr_cnt = 0, psh_cnt = 0, srt_cnt = 0, pop_cnt = 0, din_age = 0, stall_cmp = 0;
  bit chk_din = 1'b0, rdy_mode = 1'b0;
  logic [DW-1:0] md = '0, pd = '0;
  logic mc = 1'b0, ms = 1'b0, mp = 1'b0, mq = 1'b0, pv = 1'b0, pr = 1'b0;
  int c0, p0, s0, q0, cyc = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Sorter model: reacts to line changes just after each edge; busy for a few cycles per command.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (busy > 0) busy--;
      if (clear !== pc) begin n = 0; pops_since_clear = 0; busy = 3; end
      if (push !== pp) begin
        if (n < 32) begin mem[n] = din; n++; end
        busy = 3;
      end
      if (sort !== ps) begin
        for (int i = 0; i < n; i++)
          for (int j = 0; j < n - 1 - i; j++)
            if (mem[j] > mem[j+1]) begin
              logic [DW-1:0] tmp;
              tmp = mem[j]; mem[j] = mem[j+1]; mem[j+1] = tmp;
            end
        busy = 3;
      end
      if (pop !== pq) begin
        if (n > 0) begin
          for (int i = 0; i < n - 1; i++) mem[i] = mem[i+1];
          n--;
        end
        pops_since_clear++;
        busy = 3;
      end
      pc = clear; pp = push; ps = sort; pq = pop;
      idle  = (busy == 0);
      full  = (n >= 16);
      empty = (n == 0) || (fake_empty && pops_since_clear >= 2);
      dout  = (n > 0) ? mem[0] : '0;
    end
  end

  initial begin
    dn_if.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      dn_if.ready = rdy_mode ? (cyc % 3 == 0) : 1'b1;
    end
  end

  // Observer on the falling edge: toggle counts, setup time, stall stability, accepted words.
  initial begin
    forever begin
      @(negedge clk);
      if (din !== md) din_age = 0; else din_age++;
      if (clear !== mc) clr_cnt++;
      if (sort !== ms) srt_cnt++;
      if (push !== mp) begin
        psh_cnt++;
        if (chk_din) begin
          compared++;
          assert (din_age >= 10) else begin
            mismatched++;
            $error("[TB] FAIL din_setup: stable %0d cycles, expected >= 10", din_age);
          end
        end
      end
      if (pv && !pr && dn_if.valid) begin
        stall_cmp++;
        checkVal("stall_data", dn_if.data, pd);
        checkVal("stall_pop", pop, mq);
      end
      if (pop !== mq) pop_cnt++;
      if (dn_if.valid && dn_if.ready) begin
        out_q.push_back(dn_if.data);
        outl_q.push_back(dn_if.last);
        pop_at.push_back(pop_cnt);
      end
      if (up_if.valid && up_if.ready) acc_clr.push_back(clr_cnt);
      md = din; mc = clear; ms = sort; mp = push; mq = pop;
      pv = dn_if.valid; pr = dn_if.ready; pd = dn_if.data;
    end
  end

  task automatic waitState(input logic [3:0] s, input string tag);
    int t = 0;
    @(negedge clk);
    while (cst !== s && t < 3000) begin @(negedge clk); t++; end
    checkVal(tag, cst, s);
  endtask

  task automatic applyStimulus(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int t = 0;
      up_if.valid = 1'b1;
      up_if.data  = pkt[i];
      up_if.last  = (i == cnt - 1);
      @(negedge clk);
      while (!up_if.ready && t < 3000) begin @(negedge clk); t++; end
      if (!up_if.ready) begin
        compared++; mismatched++;
        $error("[TB] FAIL accept_timeout: word %0d not accepted, expected accept", i);
        break;
      end
      @(posedge clk); #1;
    end
    up_if.valid = 1'b0;
    up_if.last  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int cnt);
    int t = 0;
    while (out_q.size() < cnt && t < 5000) begin @(negedge clk); t++; end
    waitState(ST_IDLE, {tag, "_idle"});
    repeat (4) @(negedge clk);
    checkVal({tag, "_count"}, out_q.size(), cnt);
    for (int k = 0; k < cnt && k < out_q.size(); k++) begin
      checkVal($sformatf("%s_data%0d", tag, k), out_q[k], expv[k]);
      checkVal($sformatf("%s_last%0d", tag, k), outl_q[k], expl[k]);
      checkVal($sformatf("%s_popsbefore%0d", tag, k), pop_at[k] - pop_at[0], k);
    end
    out_q.delete(); outl_q.delete(); pop_at.delete();
  endtask

  task automatic snap();
    c0 = clr_cnt; p0 = psh_cnt; s0 = srt_cnt; q0 = pop_cnt;
    acc_clr.delete();
  endtask

  initial begin
    up_if.valid = 1'b0; up_if.data = '0; up_if.last = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkVal("rst_push", push, 0);   checkVal("rst_pop", pop, 0);
    checkVal("rst_clear", clear, 0); checkVal("rst_sort", sort, 0);
    checkVal("rst_din", din, 0);     checkVal("rst_err", err, 0);
    checkVal("rst_cst", cst, ST_IDLE);
    checkVal("rst_in_ready", up_if.ready, 0);
    checkVal("rst_out_valid", dn_if.valid, 0);
    checkVal("rst_out_last", dn_if.last, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while the push command is outstanding.
    up_if.valid = 1'b1; up_if.data = 16'd77; up_if.last = 1'b0;
    waitState(ST_PSH, "midpsh_reach");
    repeat (2) @(negedge clk);
    checkVal("midpsh_push_before", push, 1);
    #2 rst = 1'b1;
    up_if.valid = 1'b0;
    #1;
    checkVal("midpsh_push", push, 0);
    checkVal("midpsh_clear", clear, 0);
    checkVal("midpsh_cst", cst, ST_IDLE);
    checkVal("midpsh_din", din, 0);
    checkVal("midpsh_in_ready", up_if.ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    out_q.delete(); outl_q.delete(); pop_at.delete();

    $display("[TB] packet 5,3,9,1");
    chk_din = 1'b1;
    snap();
    pkt[0] = 5; pkt[1] = 3; pkt[2] = 9; pkt[3] = 1;
    expv[0] = 1; expv[1] = 3; expv[2] = 5; expv[3] = 9;
    expl[0] = 0; expl[1] = 0; expl[2] = 0; expl[3] = 1;
    applyStimulus(4);
    checkOutput("pktA", 4);
    checkVal("pktA_clears", clr_cnt - c0, 1);
    checkVal("pktA_pushes", psh_cnt - p0, 4);
    checkVal("pktA_sorts", srt_cnt - s0, 1);
    checkVal("pktA_pops", pop_cnt - q0, 4);
    checkVal("pktA_err", err, 0);

    $display("[TB] single word 42");
    snap();
    pkt[0] = 42; expv[0] = 42; expl[0] = 1;
    applyStimulus(1);
    checkOutput("pktB", 1);
    checkVal("pktB_pops", pop_cnt - q0, 1);
    checkVal("pktB_cst", cst, ST_IDLE);

    $display("[TB] 20-word packet split at full");
    snap();
    for (int i = 0; i < 20; i++) begin
      pkt[i]  = DW'(20 - i);
      expv[i] = (i < 16) ? DW'(i + 5) : DW'(i - 15);
      expl[i] = (i == 15) || (i == 19);
    end
    applyStimulus(20);
    checkOutput("pktC", 20);
    checkVal("pktC_clears", clr_cnt - c0, 2);
    checkVal("pktC_sorts", srt_cnt - s0, 2);
    checkVal("pktC_accepts", acc_clr.size(), 20);
    if (acc_clr.size() >= 17) begin
      checkVal("pktC_w16_clear", acc_clr[15] - c0, 1);
      checkVal("pktC_w17_clear", acc_clr[16] - c0, 2);
    end
    checkVal("pktC_err", err, 0);

    $display("[TB] downstream stalls");
    snap();
    stall_cmp = 0;
    rdy_mode = 1'b1;
    pkt[0] = 30; pkt[1] = 10; pkt[2] = 20;
    expv[0] = 10; expv[1] = 20; expv[2] = 30;
    expl[0] = 0; expl[1] = 0; expl[2] = 1;
    applyStimulus(3);
    checkOutput("pktD", 3);
    rdy_mode = 1'b0;
    checkVal("pktD_stalls_seen", (stall_cmp > 0), 1);
    checkVal("pktD_pops", pop_cnt - q0, 3);

    $display("[TB] early empty");
    fake_empty = 1'b1;
    pkt[0] = 7; pkt[1] = 8; pkt[2] = 6;
    expv[0] = 6; expv[1] = 7;
    expl[0] = 0; expl[1] = 0;
    applyStimulus(3);
    checkOutput("pktE", 2);
    checkVal("pktE_err", err, 1);
    checkVal("pktE_cst", cst, ST_IDLE);
    fake_empty = 1'b0;

    pkt[0] = 11; expv[0] = 11; expl[0] = 1;
    applyStimulus(1);
    checkOutput("pktF", 1);
    checkVal("pktF_err_sticky", err, 1);

    @(negedge clk) rst = 1'b1;
    #1;
    checkVal("final_rst_err", err, 0);
    checkVal("final_rst_cst", cst, ST_IDLE);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
